// File: rtl/mem_access_pkg.sv
// Shared definitions for the data-memory access controller.
//  - opcode encodings for loads and stores
//  - funct3 access-size encodings
//  - FSM state encoding
//  - size_mask(): byte-enable mask for an access size, before the offset shift
package mem_access_pkg;

  localparam logic [6:0] OP_LOAD  = 7'd3;
  localparam logic [6:0] OP_STORE = 7'd35;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_D  = 3'd3;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  localparam logic [2:0] F3_WU = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Unsigned variants share the width of their signed counterparts.
  function automatic logic [7:0] size_mask(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: size_mask = 8'h01;
      F3_H, F3_HU: size_mask = 8'h03;
      F3_W, F3_WU: size_mask = 8'h0F;
      default:     size_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational byte merge for the store read-modify-write.
// Ports:
//  rdata   in  64  doubleword read from memory
//  wdata   in  64  store data, right-aligned (low bytes are stored)
//  funct3  in  3   access size
//  off     in  3   byte offset inside the doubleword
//  merged  out 64  doubleword to write back
module store_merge
  import mem_access_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [63:0] wdata,
  input  logic [2:0]  funct3,
  input  logic [2:0]  off,
  output logic [63:0] merged
);

  logic [7:0]  mask;
  logic [63:0] wdata_sh;

  always_comb begin
    mask     = size_mask(funct3) << off;
    wdata_sh = wdata << {off, 3'b000};
    merged   = rdata;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) merged[8*i +: 8] = wdata_sh[8*i +: 8];
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer in front of the doubleword-wide data memory.
// Loads read the dword and right-align the addressed bytes into load_data;
// stores do read-modify-write through store_merge.
// Ports:
//  clk, reset_n          clock, async active-low reset
//  start                 request pulse, sampled only in IDLE
//  opcode, funct3        instruction fields selecting load/store and size
//  addr, store_data      byte address and store value
//  mem_rdata             memory read data
//  mem_addr, mem_wdata   dword address and merged write data
//  mem_wr                one-cycle write strobe
//  load_data             right-aligned, zero-filled load result
//  busy, done, err       status; err is meaningful while done=1
//
// state  | meaning
// IDLE   | waiting for start
// READ   | memory address presented, counting down read latency
// WRITE  | merged dword written back (mem_wr=1)
// DONE   | one-cycle completion, err valid
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [63:0] addr,
  input  logic [63:0] store_data,
  input  logic [63:0] mem_rdata,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_wr,
  output logic [63:0] load_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  // The address is registered, so READ always spans at least one cycle and
  // rdata is sampled at the end of READ cycle max(MEM_LAT,1).
  localparam logic [3:0] CNT_LOAD = (MEM_LAT == 0) ? 4'd0 : 4'(MEM_LAT - 1);

  state_e      state;
  logic        store_q;
  logic [2:0]  funct3_q;
  logic [63:0] addr_q;
  logic [63:0] store_data_q;
  logic [3:0]  cnt;
  logic        err_q;

  logic        is_load;
  logic        is_store;
  logic        illegal;
  logic        misaligned;
  logic [2:0]  off;
  logic [7:0]  ld_mask;
  logic [63:0] ld_mask64;
  logic [63:0] merged;

  always_comb begin
    is_load  = (opcode == OP_LOAD);
    is_store = (opcode == OP_STORE);
    illegal  = (is_load && funct3 == 3'd7) || (is_store && funct3 > F3_D);
    case (funct3[1:0])
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = addr[0];
      2'd2:    misaligned = |addr[1:0];
      default: misaligned = |addr[2:0];
    endcase
  end

  assign off = addr_q[2:0];

  always_comb begin
    ld_mask   = size_mask(funct3_q);
    ld_mask64 = '0;
    for (int i = 0; i < 8; i++) ld_mask64[8*i +: 8] = {8{ld_mask[i]}};
  end

  store_merge u_merge (
    .rdata  (mem_rdata),
    .wdata  (store_data_q),
    .funct3 (funct3_q),
    .off    (off),
    .merged (merged)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      store_q      <= 1'b0;
      funct3_q     <= '0;
      addr_q       <= '0;
      store_data_q <= '0;
      cnt          <= '0;
      err_q        <= 1'b0;
      load_data    <= '0;
      mem_wdata    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && (is_load || is_store)) begin
            store_q      <= is_store;
            funct3_q     <= funct3;
            addr_q       <= addr;
            store_data_q <= store_data;
            if (illegal || misaligned) begin
              err_q <= 1'b1;
              state <= ST_DONE;
            end else begin
              err_q <= 1'b0;
              cnt   <= CNT_LOAD;
              state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (cnt == 4'd0) begin
            if (store_q) begin
              mem_wdata <= merged;
              state     <= ST_WRITE;
            end else begin
              load_data <= (mem_rdata >> {off, 3'b000}) & ld_mask64;
              state     <= ST_DONE;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_WRITE: state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Decoded straight from state so reset removes mem_wr without waiting a clock.
  assign mem_addr = {addr_q[63:3], 3'b000};
  assign mem_wr   = (state == ST_WRITE);
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign err      = (state == ST_DONE) && err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        clk;
  logic        reset_n;

  logic        start, start3;
  logic [6:0]  opcode, opcode3;
  logic [2:0]  funct3, funct33;
  logic [63:0] addr, addr3;
  logic [63:0] store_data, store_data3;
  logic [63:0] mem_rdata, mem_rdata3;
  logic [63:0] mem_addr, mem_addr3;
  logic [63:0] mem_wdata, mem_wdata3;
  logic        mem_wr, mem_wr3;
  logic [63:0] load_data, load_data3;
  logic        busy, busy3, done, done3, err, err3;

  logic [63:0] mem1 [64];
  logic [63:0] mem3 [64];
  logic [63:0] pipe3_a, pipe3_b;
  logic        pre_we;
  logic [5:0]  pre_idx;
  logic [63:0] pre_val;
  int          wr_count, wr3_count;

  int checks;
  int failures;
  int ndone;

  mem_access_ctrl #(.MEM_LAT(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .opcode(opcode), .funct3(funct3),
    .addr(addr), .store_data(store_data), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wr(mem_wr), .load_data(load_data), .busy(busy),
    .done(done), .err(err)
  );

  mem_access_ctrl #(.MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .start(start3), .opcode(opcode3), .funct3(funct33),
    .addr(addr3), .store_data(store_data3), .mem_rdata(mem_rdata3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_wr(mem_wr3), .load_data(load_data3), .busy(busy3),
    .done(done3), .err(err3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // MEM_LAT=1 memory: data valid by the end of the first address cycle.
  assign mem_rdata  = mem1[mem_addr[8:3]];
  // MEM_LAT=3 memory: two extra register stages.
  assign mem_rdata3 = pipe3_b;

  always @(posedge clk) begin
    if (pre_we) begin
      mem1[pre_idx] <= pre_val;
      mem3[pre_idx] <= pre_val;
    end else begin
      if (mem_wr)  mem1[mem_addr[8:3]]  <= mem_wdata;
      if (mem_wr3) mem3[mem_addr3[8:3]] <= mem_wdata3;
    end
    pipe3_a <= mem3[mem_addr3[8:3]];
    pipe3_b <= pipe3_a;
    if (mem_wr)  wr_count  <= wr_count + 1;
    if (mem_wr3) wr3_count <= wr3_count + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request during cycle s; returns at cycle s+1.
  task automatic launch(input logic [6:0] op, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] sd);
    opcode     = op;
    funct3     = f3;
    addr       = a;
    store_data = sd;
    start      = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0; ndone = 0;
    wr_count = 0; wr3_count = 0;
    reset_n = 1'b0;
    start = 0; opcode = 0; funct3 = 0; addr = 0; store_data = 0;
    start3 = 0; opcode3 = 0; funct33 = 0; addr3 = 0; store_data3 = 0;
    pre_we = 1'b1; pre_idx = 6'd32; pre_val = 64'h1122334455667788;
    tick();
    pre_we = 1'b0;
    tick();

    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_load_data", load_data, 0);

    reset_n = 1'b1;
    tick();

    // ld 0x100
    launch(7'd3, 3'd3, 64'h100, 64'h0);
    chk("ld_busy_s1", busy, 1);
    chk("ld_done_s1", done, 0);
    chk("ld_mem_addr", mem_addr, 64'h100);
    tick();
    chk("ld_done_s2", done, 1);
    chk("ld_err", err, 0);
    chk("ld_data", load_data, 64'h1122334455667788);
    tick();
    chk("ld_idle_busy", busy, 0);
    chk("ld_idle_done", done, 0);
    chk("ld_data_hold", load_data, 64'h1122334455667788);

    // lbu 0x105
    launch(7'd3, 3'd4, 64'h105, 64'h0);
    chk("lbu_mem_addr", mem_addr, 64'h100);
    tick();
    chk("lbu_done", done, 1);
    chk("lbu_data", load_data, 64'h33);
    tick();
    chk("lbu_no_wr", wr_count, 0);

    // sh 0x102
    launch(7'd35, 3'd1, 64'h102, 64'hABCD);
    chk("sh_wr_s1", mem_wr, 0);
    tick();
    chk("sh_wr_s2", mem_wr, 1);
    chk("sh_done_s2", done, 0);
    chk("sh_wdata", mem_wdata, 64'h11223344ABCD7788);
    tick();
    chk("sh_done_s3", done, 1);
    chk("sh_err", err, 0);
    chk("sh_wr_s3", mem_wr, 0);
    tick();
    chk("sh_mem", mem1[32], 64'h11223344ABCD7788);
    chk("sh_wr_count", wr_count, 1);

    // sw 0x106 misaligned
    launch(7'd35, 3'd2, 64'h106, 64'h55AA55AA);
    chk("sw_mis_done", done, 1);
    chk("sw_mis_err", err, 1);
    chk("sw_mis_wr", mem_wr, 0);
    tick();
    chk("sw_mis_done_s2", done, 0);
    chk("sw_mis_wr_count", wr_count, 1);
    chk("sw_mis_mem", mem1[32], 64'h11223344ABCD7788);
    chk("sw_mis_ld_hold", load_data, 64'h33);

    // illegal store size, illegal load size, ignored opcode
    launch(7'd35, 3'd4, 64'h100, 64'h0);
    chk("st_ill_done", done, 1);
    chk("st_ill_err", err, 1);
    tick();
    launch(7'd3, 3'd7, 64'h100, 64'h0);
    chk("ld_ill_done", done, 1);
    chk("ld_ill_err", err, 1);
    tick();
    launch(7'd51, 3'd0, 64'h100, 64'h0);
    chk("ign_busy", busy, 0);
    chk("ign_done", done, 0);
    tick();
    chk("ill_wr_count", wr_count, 1);

    // sd aborted by reset during READ
    launch(7'd35, 3'd3, 64'h100, 64'hDEAD);
    chk("rst_mid_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_busy0", busy, 0);
    chk("rst_mid_wr0", mem_wr, 0);
    chk("rst_mid_addr0", mem_addr, 0);
    chk("rst_mid_wdata0", mem_wdata, 0);
    chk("rst_mid_ld0", load_data, 0);
    tick();
    tick();
    chk("rst_mid_wr_held", mem_wr, 0);
    reset_n = 1'b1;
    tick();
    tick();
    chk("rst_mid_wr_count", wr_count, 1);
    chk("rst_mid_mem", mem1[32], 64'h11223344ABCD7788);
    chk("rst_mid_idle", busy, 0);

    // back-to-back loads with start held high, MEM_LAT=3
    opcode3 = 7'd3; funct33 = 3'd3; addr3 = 64'h100; store_data3 = 64'h0;
    start3 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk($sformatf("b2b_done_%0d", i), done3, ((i % 5) == 4) ? 64'd1 : 64'd0);
      chk($sformatf("b2b_busy_%0d", i), busy3, ((i % 5) != 0) ? 64'd1 : 64'd0);
      if ((i % 5) == 4)
        chk($sformatf("b2b_data_%0d", i), load_data3, 64'h1122334455667788);
      if (done3) ndone++;
    end
    start3 = 1'b0;
    chk("b2b_ndone", ndone, 4);
    chk("b2b_no_wr", wr3_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
